// File: rtl/ctrl_wr_sched.sv
// Write-data launch scheduler: queues issued WR commands, counts CAS write latency,
// drives the wr_rdy window and enforces tWTR. Define WR_SEAMLESS_EN for preamble-free chaining.
module ctrl_wr_sched #(
  parameter int DEPTH = 4,
  parameter int TWTR  = 4
) (
  input  logic       CK_t,
  input  logic       reset,
  input  logic       wr_cmd_valid,
  input  logic       wr_cmd_bl8,
  input  logic       wr_cmd_pre2,
  input  logic [4:0] cwl,
  output logic       wr_cmd_ready,
  output logic       wr_start,
  output logic       wr_rdy,
  output logic       wr_burst_bl8,
  output logic [1:0] wr_burst_pre,
  output logic       rd_block,
  output logic       drop_err,
  output logic       overlap_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam int CW = $clog2(((TWTR > 4) ? TWTR : 4) + 1);
  localparam int RW = CW + 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_DATA, S_WTR} state_t;

  state_t        r_state;
  logic [4:0]    r_q_cnt  [DEPTH];
  logic          r_q_bl8  [DEPTH];
  logic          r_q_pre2 [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [NW-1:0] r_count;
  logic [4:0]    r_cwl;
  logic [CW-1:0] r_phase;
  logic          r_head_eval;
  logic          r_head_seam;
  logic          r_wr_cmd_ready;
  logic          r_wr_start;
  logic          r_wr_rdy;
  logic          r_wr_burst_bl8;
  logic [1:0]    r_wr_burst_pre;
  logic          r_rd_block;
  logic          r_drop_err;
  logic          r_overlap_err;

  logic          w_idle;
  logic [4:0]    w_cwl;
  logic [4:0]    w_push_cnt;
  logic          w_head_due;
  logic          w_head_bl8;
  logic          w_head_pre2;
  logic          w_last_data;
  logic          w_launch;
  logic          w_seam;
  logic          w_full;
  logic          w_push;
  logic [NW-1:0] w_count_next;
  logic          w_seam_ok;

  assign w_idle       = (r_state == S_IDLE) && (r_count == '0);
  assign w_cwl        = w_idle ? cwl : r_cwl;
  assign w_push_cnt   = w_cwl - (wr_cmd_pre2 ? 5'd2 : 5'd1) - 5'd1;
  assign w_head_due   = (r_count != '0) && (r_q_cnt[r_rd_ptr] == 5'd0);
  assign w_head_bl8   = r_q_bl8[r_rd_ptr];
  assign w_head_pre2  = r_q_pre2[r_rd_ptr];
  assign w_last_data  = (r_state == S_DATA) && (r_phase == CW'(1));
  assign w_launch     = w_head_due && ((r_state == S_IDLE) || (r_state == S_WAIT) ||
                                       (r_state == S_WTR) || w_last_data);
  assign w_seam       = w_launch && w_last_data && r_head_seam;
  assign w_full       = (r_count == NW'(DEPTH)) && !w_launch;
  assign w_push       = wr_cmd_valid && !w_full;
  assign w_count_next = r_count + NW'(w_push) - NW'(w_launch);

`ifdef WR_SEAMLESS_EN
  logic [RW-1:0] w_rem;
  // Bus cycles left in the active burst, including the current one.
  assign w_rem = (r_state == S_PRE) ?
                 (RW'(r_phase) + (r_wr_burst_bl8 ? RW'(4) : RW'(2))) : RW'(r_phase);
  assign w_seam_ok = (w_rem == (w_head_pre2 ? RW'(3) : RW'(2)));
`else
  assign w_seam_ok = 1'b0;
`endif

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_cnt[i]  <= 5'd0;
        r_q_bl8[i]  <= 1'b0;
        r_q_pre2[i] <= 1'b0;
      end
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_cwl          <= 5'd0;
      r_head_eval    <= 1'b0;
      r_head_seam    <= 1'b0;
      r_wr_cmd_ready <= 1'b1;
      r_drop_err     <= 1'b0;
      r_overlap_err  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q_cnt[i] != 5'd0) r_q_cnt[i] <= r_q_cnt[i] - 5'd1;
      end
      if (w_push) begin
        r_q_cnt[r_wr_ptr]  <= w_push_cnt;
        r_q_bl8[r_wr_ptr]  <= wr_cmd_bl8;
        r_q_pre2[r_wr_ptr] <= wr_cmd_pre2;
        r_wr_ptr           <= r_wr_ptr + AW'(1);
      end
      if (w_launch) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count        <= w_count_next;
      r_wr_cmd_ready <= (w_count_next != NW'(DEPTH));
      if (w_idle) r_cwl <= cwl;
      if (wr_cmd_valid && w_full) r_drop_err <= 1'b1;
      // A head due while the bus is busy is judged once: chain seamlessly or record a late launch.
      // Due in the last data cycle is on time and launches at the next edge.
      if (w_launch) begin
        r_head_eval <= 1'b0;
        r_head_seam <= 1'b0;
      end else if (w_head_due && !r_head_eval && ((r_state == S_PRE) || (r_state == S_DATA))) begin
        r_head_eval <= 1'b1;
        if (w_seam_ok) r_head_seam   <= 1'b1;
        else           r_overlap_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_wr_start     <= 1'b0;
      r_wr_rdy       <= 1'b0;
      r_wr_burst_bl8 <= 1'b0;
      r_wr_burst_pre <= 2'd0;
      r_rd_block     <= 1'b0;
    end else begin
      r_wr_start <= 1'b0;
      r_wr_rdy   <= 1'b0;
      r_rd_block <= 1'b1;
      if (w_launch) begin
        r_wr_start     <= 1'b1;
        r_wr_rdy       <= 1'b1;
        r_wr_burst_bl8 <= w_head_bl8;
        if (w_seam) begin
          r_state        <= S_DATA;
          r_phase        <= w_head_bl8 ? CW'(4) : CW'(2);
          r_wr_burst_pre <= 2'd0;
        end else begin
          r_state        <= S_PRE;
          r_phase        <= w_head_pre2 ? CW'(2) : CW'(1);
          r_wr_burst_pre <= w_head_pre2 ? 2'd2 : 2'd1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_push) r_state <= S_WAIT;
            else        r_rd_block <= 1'b0;
          end
          S_WAIT: r_state <= S_WAIT;
          S_PRE: begin
            r_wr_rdy <= 1'b1;
            if (r_phase == CW'(1)) begin
              r_state <= S_DATA;
              r_phase <= r_wr_burst_bl8 ? CW'(4) : CW'(2);
            end else begin
              r_phase <= r_phase - CW'(1);
            end
          end
          S_DATA: begin
            if (r_phase == CW'(1)) begin
              if (w_count_next != '0) begin
                r_state <= S_WAIT;
              end else begin
                r_state <= S_WTR;
                r_phase <= CW'(TWTR);
              end
            end else begin
              r_wr_rdy <= 1'b1;
              r_phase  <= r_phase - CW'(1);
            end
          end
          S_WTR: begin
            if (w_push) begin
              r_state <= S_WAIT;
            end else if (r_phase == CW'(1)) begin
              r_state    <= S_IDLE;
              r_rd_block <= 1'b0;
            end else begin
              r_phase <= r_phase - CW'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_rd_block <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_cmd_ready = r_wr_cmd_ready;
  assign wr_start     = r_wr_start;
  assign wr_rdy       = r_wr_rdy;
  assign wr_burst_bl8 = r_wr_burst_bl8;
  assign wr_burst_pre = r_wr_burst_pre;
  assign rd_block     = r_rd_block;
  assign drop_err     = r_drop_err;
  assign overlap_err  = r_overlap_err;

endmodule

// File: tb/tb_ctrl_wr_sched.sv
// Directed bench for ctrl_wr_sched: table of one/two-write scenarios plus full-queue and reset sequences.
module tb_ctrl_wr_sched;
  logic       CK_t = 1'b0;
  logic       reset = 1'b0;
  logic       wr_cmd_valid = 1'b0;
  logic       wr_cmd_bl8 = 1'b0;
  logic       wr_cmd_pre2 = 1'b0;
  logic [4:0] cwl = 5'd12;
  logic       wr_cmd_ready, wr_start, wr_rdy, wr_burst_bl8, rd_block, drop_err, overlap_err;
  logic [1:0] wr_burst_pre;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_wr_sched #(.DEPTH(4), .TWTR(4)) u_dut (
    .CK_t(CK_t), .reset(reset), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_bl8(wr_cmd_bl8),
    .wr_cmd_pre2(wr_cmd_pre2), .cwl(cwl), .wr_cmd_ready(wr_cmd_ready), .wr_start(wr_start),
    .wr_rdy(wr_rdy), .wr_burst_bl8(wr_burst_bl8), .wr_burst_pre(wr_burst_pre),
    .rd_block(rd_block), .drop_err(drop_err), .overlap_err(overlap_err)
  );

  always #5 CK_t = ~CK_t;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CK_t);
    wr_cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge CK_t);
    reset = 1'b0;
  endtask

  // t2: edge index of the second write (-1 none); s*: wr_start cycles; lo/hi: wr_rdy windows.
  typedef struct {
    int         t2;
    logic       bl8;
    logic       pre2;
    logic [4:0] cwl;
    int         s1, s2, lo1, hi1, lo2, hi2, rb_last;
    logic       ovl;
    logic [1:0] pre_2nd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int starts;
    int first;
    int late_pulses;

    vecs[0] = '{-1, 1'b1, 1'b0, 5'd12, 11, -1, 11, 15, -1, -1, 19, 1'b0, 2'd0};
`ifdef WR_SEAMLESS_EN
    vecs[1] = '{ 4, 1'b1, 1'b0, 5'd12, 11, 16, 11, 15, 16, 19, 23, 1'b0, 2'd0};
`else
    vecs[1] = '{ 4, 1'b1, 1'b0, 5'd12, 11, 16, 11, 15, 16, 20, 24, 1'b1, 2'd1};
`endif
    vecs[2] = '{ 6, 1'b0, 1'b1, 5'd12, 10, 16, 10, 13, 16, 19, 23, 1'b0, 2'd2};
    vecs[3] = '{-1, 1'b0, 1'b1, 5'd5,   3, -1,  3,  6, -1, -1, 10, 1'b0, 2'd0};
    vecs[4] = '{-1, 1'b1, 1'b1, 5'd20, 18, -1, 18, 23, -1, -1, 27, 1'b0, 2'd0};
    vecs[5] = '{ 3, 1'b0, 1'b0, 5'd12, 11, 14, 11, 13, 14, 16, 20, 1'b0, 2'd1};

    // Reset state, checked while reset is held and before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 0, wr_cmd_ready, 1);
    check("rst_start", 0, wr_start, 0);
    check("rst_rdy", 0, wr_rdy, 0);
    check("rst_rd_block", 0, rd_block, 0);
    check("rst_drop", 0, drop_err, 0);
    check("rst_overlap", 0, overlap_err, 0);
    check("rst_pre", 0, wr_burst_pre, 0);
    @(negedge CK_t);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      @(negedge CK_t);
      wr_cmd_valid = 1'b1;
      wr_cmd_bl8   = vecs[v].bl8;
      wr_cmd_pre2  = vecs[v].pre2;
      cwl          = vecs[v].cwl;
      for (int n = 0; n < 40; n++) begin
        @(posedge CK_t);
        #1;
        wr_cmd_valid = (vecs[v].t2 == n + 1);
        if (n == 0) cwl = 5'd7;  // must be ignored while the block is busy
        check($sformatf("vec%0d_start", v), n, wr_start,
              (n == vecs[v].s1) || (n == vecs[v].s2));
        check($sformatf("vec%0d_rdy", v), n, wr_rdy,
              ((n >= vecs[v].lo1) && (n <= vecs[v].hi1)) || ((n >= vecs[v].lo2) && (n <= vecs[v].hi2)));
        check($sformatf("vec%0d_rd_block", v), n, rd_block, n <= vecs[v].rb_last);
        if (n == vecs[v].s1) begin
          check($sformatf("vec%0d_pre1", v), n, wr_burst_pre, vecs[v].pre2 ? 2 : 1);
          check($sformatf("vec%0d_bl8", v), n, wr_burst_bl8, vecs[v].bl8);
        end
        if (n == vecs[v].s2) check($sformatf("vec%0d_pre2nd", v), n, wr_burst_pre, vecs[v].pre_2nd);
      end
      check($sformatf("vec%0d_overlap", v), 39, overlap_err, vecs[v].ovl);
      check($sformatf("vec%0d_drop", v), 39, drop_err, 0);
      cwl = 5'd12;
    end

    // Full queue: five writes on consecutive edges E0..E4, cwl=20, BL8, pre=1.
    do_reset();
    @(negedge CK_t);
    wr_cmd_valid = 1'b1;
    wr_cmd_bl8   = 1'b1;
    wr_cmd_pre2  = 1'b0;
    cwl          = 5'd20;
    starts = 0;
    first  = -1;
    for (int n = 0; n < 90; n++) begin
      @(posedge CK_t);
      #1;
      wr_cmd_valid = (n + 1 <= 4);
      if (wr_start) begin
        starts++;
        if (first < 0) first = n;
      end
      if (n == 2)  check("full_ready_3", n, wr_cmd_ready, 1);
      if (n == 3)  check("full_ready_4", n, wr_cmd_ready, 0);
      if (n == 3)  check("full_drop_pre", n, drop_err, 0);
      if (n == 4)  check("full_drop", n, drop_err, 1);
      if (n == 18) check("full_ready_prepop", n, wr_cmd_ready, 0);
      if (n == 19) check("full_ready_pop", n, wr_cmd_ready, 1);
    end
    check("full_start_count", 89, starts, 4);
    check("full_first_start", 89, first, 19);
    check("full_idle_rd_block", 89, rd_block, 0);

    // Reset in cycle 13 of a single write; also clears the sticky drop_err left above.
    @(negedge CK_t);
    wr_cmd_valid = 1'b1;
    cwl          = 5'd12;
    for (int n = 0; n < 14; n++) begin
      @(posedge CK_t);
      #1;
      wr_cmd_valid = 1'b0;
    end
    check("mid_rdy_before", 13, wr_rdy, 1);
    reset = 1'b1;
    #1;
    check("mid_rdy", 13, wr_rdy, 0);
    check("mid_rd_block", 13, rd_block, 0);
    check("mid_start", 13, wr_start, 0);
    check("mid_ready", 13, wr_cmd_ready, 1);
    check("mid_drop_cleared", 13, drop_err, 0);
    check("mid_overlap", 13, overlap_err, 0);
    @(negedge CK_t);
    reset = 1'b0;
    late_pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge CK_t);
      #1;
      if (wr_start || wr_rdy || rd_block) late_pulses++;
    end
    check("mid_no_activity", 44, late_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
